// File: rtl/fetch_unit.sv
// Instruction fetch / program-counter stage of the 8-bit datapath.
// Fetches one byte per memory handshake into IR and advances pc on each accept.
module fetch_unit #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    output logic       imem_req,
    output logic [7:0] imem_addr,
    input  logic       imem_ack,
    input  logic [7:0] imem_data,
    output logic [7:0] instr,
    output logic [3:0] opcode,
    output logic [1:0] rs,
    output logic [1:0] imm2,
    output logic       instr_valid,
    input  logic       instr_ready,
    input  logic       branch_taken,
    input  logic [7:0] branch_offset,
    input  logic       halt,
    output logic [7:0] pc
);

    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_HALT  = 2'd3
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_START;
            pc_q    <= RESET_PC;
            ir_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            S_START: state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_data;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Branch target is relative to the following instruction; wraps mod 256.
                if (instr_ready) begin
                    pc_d    = pc_q + 8'd1 + (branch_taken ? branch_offset : 8'h00);
                    state_d = halt ? S_HALT : S_FETCH;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_START;
        endcase
    end

    assign imem_req    = (state_q == S_FETCH);
    assign instr_valid = (state_q == S_ISSUE);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = ir_q;
    assign opcode      = ir_q[7:4];
    assign rs          = ir_q[3:2];
    assign imm2        = ir_q[1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a table of instructions walked through fetch/issue, plus
// hand-written reset, halt and reset-during-ack sequences.
module tb_fetch_unit;

    localparam logic [7:0] RPC = 8'h10;

    logic       clk = 1'b0;
    logic       reset;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_data;
    logic [7:0] instr;
    logic [3:0] opcode;
    logic [1:0] rs;
    logic [1:0] imm2;
    logic       instr_valid;
    logic       instr_ready;
    logic       branch_taken;
    logic [7:0] branch_offset;
    logic       halt;
    logic [7:0] pc;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .instr(instr), .opcode(opcode), .rs(rs), .imm2(imm2),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .branch_taken(branch_taken), .branch_offset(branch_offset),
        .halt(halt), .pc(pc)
    );

    typedef struct {
        logic [7:0] pc;
        logic [7:0] dat;
        int         dly;
        int         stall;
        logic       tk;
        logic [7:0] off;
        logic       hlt;
        logic [7:0] nxt;
        logic [3:0] op;
        logic [1:0] rs;
        logic [1:0] imm;
    } vec_t;

    vec_t       v[11];
    int         nvec = 0;
    int         nmis = 0;
    logic [7:0] addr_sb[$];
    logic [7:0] ir_sb[$];
    logic [7:0] exp_v;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    task automatic idle_in();
        imem_ack      = 1'b0;
        instr_ready   = 1'b0;
        branch_taken  = 1'b0;
        branch_offset = 8'h00;
        halt          = 1'b0;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!imem_req && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (!imem_req) begin
            nvec++;
            nmis++;
            $display("FAIL req_timeout: imem_req still 0 after %0d cycles", n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //        pc     data   dly stall tk    off    halt  next   op    rs     imm
        v[0]  = '{8'h10, 8'hA7, 2, 5, 1'b0, 8'h00, 1'b0, 8'h11, 4'hA, 2'b01, 2'b11};
        v[1]  = '{8'h11, 8'h3C, 2, 0, 1'b1, 8'hF0, 1'b0, 8'h02, 4'h3, 2'b11, 2'b00};
        v[2]  = '{8'h02, 8'h5E, 1, 0, 1'b1, 8'hFE, 1'b0, 8'h01, 4'h5, 2'b11, 2'b10};
        v[3]  = '{8'h01, 8'h81, 0, 0, 1'b1, 8'hFD, 1'b0, 8'hFF, 4'h8, 2'b00, 2'b01};
        v[4]  = '{8'hFF, 8'hF2, 1, 0, 1'b0, 8'h00, 1'b0, 8'h00, 4'hF, 2'b00, 2'b10};
        v[5]  = '{8'h00, 8'h14, 0, 1, 1'b1, 8'h7E, 1'b0, 8'h7F, 4'h1, 2'b01, 2'b00};
        v[6]  = '{8'h7F, 8'h69, 0, 0, 1'b1, 8'h01, 1'b0, 8'h81, 4'h6, 2'b10, 2'b01};
        v[7]  = '{8'h81, 8'hC3, 3, 0, 1'b1, 8'h7C, 1'b0, 8'hFE, 4'hC, 2'b00, 2'b11};
        v[8]  = '{8'hFE, 8'h2D, 0, 0, 1'b1, 8'h01, 1'b0, 8'h00, 4'h2, 2'b11, 2'b01};
        v[9]  = '{8'h00, 8'h9B, 0, 0, 1'b1, 8'h1F, 1'b0, 8'h20, 4'h9, 2'b10, 2'b11};
        v[10] = '{8'h20, 8'hE0, 1, 2, 1'b1, 8'h01, 1'b1, 8'h22, 4'hE, 2'b00, 2'b00};

        idle_in();
        imem_data = 8'h00;
        reset     = 1'b1;

        // Reset cycle and the following START cycle both keep imem_req low.
        @(negedge clk);
        chk("rst_req0", {7'd0, imem_req}, 8'h00);
        @(negedge clk);
        chk("rst_pc", pc, RPC);
        chk("rst_req1", {7'd0, imem_req}, 8'h00);
        chk("rst_valid", {7'd0, instr_valid}, 8'h00);
        chk("rst_ir", instr, 8'h00);
        reset = 1'b0;
        addr_sb.push_back(RPC);
        @(negedge clk);
        chk("first_req", {7'd0, imem_req}, 8'h01);

        for (int i = 0; i < 11; i++) begin
            wait_req();
            chk($sformatf("v%0d_addr", i), imem_addr, addr_sb.pop_front());
            chk($sformatf("v%0d_pc", i), pc, v[i].pc);
            // Accept-side inputs toggled during FETCH must be ignored.
            for (int d = 0; d < v[i].dly; d++) begin
                imem_ack      = 1'b0;
                instr_ready   = 1'b1;
                branch_taken  = 1'b1;
                branch_offset = 8'h55;
                halt          = 1'b1;
                @(negedge clk);
                chk($sformatf("v%0d_addr_hold", i), imem_addr, v[i].pc);
                chk($sformatf("v%0d_req_hold", i), {7'd0, imem_req}, 8'h01);
            end
            idle_in();
            imem_ack  = 1'b1;
            imem_data = v[i].dat;
            ir_sb.push_back(v[i].dat);
            @(negedge clk);
            imem_ack  = 1'b0;
            imem_data = 8'($urandom);
            chk($sformatf("v%0d_valid", i), {7'd0, instr_valid}, 8'h01);
            chk($sformatf("v%0d_instr", i), instr, ir_sb.pop_front());
            chk($sformatf("v%0d_opcode", i), {4'd0, opcode}, {4'd0, v[i].op});
            chk($sformatf("v%0d_rs", i), {6'd0, rs}, {6'd0, v[i].rs});
            chk($sformatf("v%0d_imm2", i), {6'd0, imm2}, {6'd0, v[i].imm});
            for (int s = 0; s < v[i].stall; s++) begin
                imem_ack = 1'b1;
                @(negedge clk);
                chk($sformatf("v%0d_stall_valid", i), {7'd0, instr_valid}, 8'h01);
                chk($sformatf("v%0d_stall_req", i), {7'd0, imem_req}, 8'h00);
                chk($sformatf("v%0d_stall_pc", i), pc, v[i].pc);
                chk($sformatf("v%0d_stall_ir", i), instr, v[i].dat);
            end
            imem_ack      = 1'b0;
            instr_ready   = 1'b1;
            branch_taken  = v[i].tk;
            branch_offset = v[i].off;
            halt          = v[i].hlt;
            addr_sb.push_back(v[i].nxt);
            @(negedge clk);
            idle_in();
        end

        // Halted: pc holds the branch target, nothing restarts fetch.
        exp_v = addr_sb.pop_front();
        for (int h = 0; h < 6; h++) begin
            imem_ack    = 1'b1;
            instr_ready = 1'b1;
            @(negedge clk);
            chk("halt_pc", pc, exp_v);
            chk("halt_req", {7'd0, imem_req}, 8'h00);
            chk("halt_valid", {7'd0, instr_valid}, 8'h00);
        end
        idle_in();

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rehalt_pc", pc, RPC);
        chk("rehalt_req0", {7'd0, imem_req}, 8'h00);
        @(negedge clk);
        chk("rehalt_req1", {7'd0, imem_req}, 8'h01);
        chk("rehalt_addr", imem_addr, RPC);

        // Reset coincident with an ack in FETCH: the ack is dropped.
        reset     = 1'b1;
        imem_ack  = 1'b1;
        imem_data = 8'h5A;
        @(negedge clk);
        reset    = 1'b0;
        imem_ack = 1'b0;
        chk("rstack_ir", instr, 8'h00);
        chk("rstack_valid", {7'd0, instr_valid}, 8'h00);
        chk("rstack_pc", pc, RPC);
        chk("rstack_req0", {7'd0, imem_req}, 8'h00);
        @(negedge clk);
        chk("rstack_req1", {7'd0, imem_req}, 8'h01);
        chk("rstack_addr", imem_addr, RPC);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
